// File: rtl/master_rd_data_fifo_rdctrl.sv
// Read-side controller for a master read-data FIFO. It prefetches beats
// from a 1-cycle-latency FIFO into a 2-entry output buffer and uses a
// queue of burst lengths to present them as R-channel bursts with m_last.
module master_rd_data_fifo_rdctrl #(
  parameter int c_DATA_WIDTH           = 32,
  parameter int c_LEN_QUEUE_DEPTH_WIDTH = 2
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                    fifo_rd_empty,
  output logic                    fifo_rd_en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_len,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy
);

  localparam int QW = c_LEN_QUEUE_DEPTH_WIDTH;
  localparam int QD = 1 << QW;

  // output buffer: two entries, ping-pong pointers
  logic [1:0][c_DATA_WIDTH-1:0] obuf;
  logic                         wr_ptr, rd_ptr;
  logic [1:0]                   occ;
  logic                         inflight;

  // burst-length queue
  logic [QD-1:0][7:0] lq;
  logic [QW-1:0]      q_wr, q_rd;
  logic [QW:0]        q_cnt, q_cnt_nxt;
  logic               q_full;
  logic [7:0]         beat_cnt;

  logic       has_beat, has_cmd, xfer, push, qpop;
  logic [2:0] pend;

  // handshakes, prefetch decision and reset-gated outputs
  always_comb begin
    has_beat  = (occ != 2'd0);
    has_cmd   = (q_cnt != '0);
    m_valid   = !rd_rst && has_beat && has_cmd;
    m_data    = rd_rst ? '0 : obuf[rd_ptr];
    m_last    = m_valid && (beat_cnt == lq[q_rd]);
    xfer      = m_valid && m_ready;
    qpop      = xfer && m_last;
    cmd_ready = !rd_rst && !q_full;
    push      = cmd_valid && cmd_ready;
    busy      = !rd_rst && (has_cmd || has_beat || inflight);
    // slots already claimed after this cycle's transfer; xfer implies occ>0
    pend       = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    fifo_rd_en = !rd_rst && !fifo_rd_empty && (pend < 3'd2);
    q_cnt_nxt  = q_cnt + {{QW{1'b0}}, push} - {{QW{1'b0}}, qpop};
  end

  // output buffer: capture the beat popped last cycle, release on transfer
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      obuf     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      if (inflight) begin
        obuf[wr_ptr] <= fifo_rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      occ      <= occ + {1'b0, inflight} - {1'b0, xfer};
      inflight <= fifo_rd_en;
    end
  end

  // length queue and beat counter of the head burst
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      lq       <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      q_full   <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      if (push) begin
        lq[q_wr] <= cmd_len;
        q_wr     <= q_wr + 1'b1;
      end
      if (qpop) q_rd <= q_rd + 1'b1;
      q_cnt  <= q_cnt_nxt;
      q_full <= (q_cnt_nxt == (QW+1)'(QD));
      if (xfer) beat_cnt <= m_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

endmodule
